// File: rtl/uart_pe.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pe
//  Description : Full-duplex UART with configurable word length, parity and
//                stop bits; 3-sample majority-voted receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_pe #(
   parameter int BIT_LEN      = 7,
   parameter int CLKS_PER_BIT = 8,
   parameter int PARITY_MODE  = 1,
   parameter int STOP_BITS    = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tx_start,
   input  logic [BIT_LEN-1:0] tx_data_in,
   output logic               tx_channel_out,
   output logic               tx_busy,
   input  logic               rx_channel_in,
   output logic [BIT_LEN-1:0] rx_data_out,
   output logic               rx_out_vaild,
   output logic               rx_busy,
   output logic               rx_parity_err,
   output logic               rx_frame_err
);

   localparam int c_CW = $clog2(CLKS_PER_BIT);
   localparam int c_IW = $clog2(BIT_LEN);
   localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(CLKS_PER_BIT - 1);
   localparam logic [c_CW-1:0] c_S0       = c_CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [c_CW-1:0] c_S1       = c_CW'(CLKS_PER_BIT / 2);
   localparam logic [c_CW-1:0] c_S2       = c_CW'(CLKS_PER_BIT / 2 + 1);
   localparam logic [c_IW-1:0] c_IDX_LAST = c_IW'(BIT_LEN - 1);
   localparam logic c_PAR_EN    = (PARITY_MODE != 0);
   localparam logic c_ODD       = (PARITY_MODE == 2);
   localparam logic c_STOP_LAST = (STOP_BITS == 2);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   // ------------------------------------------------------------------ TX
   state_t              r_tx_state, w_tx_nxt;
   logic [c_CW-1:0]     r_tx_cnt, w_tx_cnt_nxt;
   logic [c_IW-1:0]     r_tx_idx, w_tx_idx_nxt;
   logic                r_tx_stop, w_tx_stop_nxt;
   logic [BIT_LEN-1:0]  r_tx_data;
   logic                r_tx_line, w_tx_line, w_tx_load, w_tx_cnt_end;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tx_state <= S_IDLE;
         r_tx_cnt   <= '0;
         r_tx_idx   <= '0;
         r_tx_stop  <= 1'b0;
         r_tx_data  <= '0;
         r_tx_line  <= 1'b1;
      end else begin
         r_tx_state <= w_tx_nxt;
         r_tx_cnt   <= w_tx_cnt_nxt;
         r_tx_idx   <= w_tx_idx_nxt;
         r_tx_stop  <= w_tx_stop_nxt;
         r_tx_line  <= w_tx_line;
         if (w_tx_load) r_tx_data <= tx_data_in;
      end
   end

   always_comb begin
      w_tx_nxt      = r_tx_state;
      w_tx_cnt_nxt  = r_tx_cnt;
      w_tx_idx_nxt  = r_tx_idx;
      w_tx_stop_nxt = r_tx_stop;
      w_tx_load     = 1'b0;
      w_tx_cnt_end  = (r_tx_cnt == c_CNT_LAST);
      if (r_tx_state != S_IDLE)
         w_tx_cnt_nxt = w_tx_cnt_end ? '0 : r_tx_cnt + 1'b1;
      case (r_tx_state)
         S_IDLE: begin
            if (tx_start) begin
               w_tx_nxt     = S_START;
               w_tx_load    = 1'b1;
               w_tx_cnt_nxt = '0;
            end
         end
         S_START: begin
            if (w_tx_cnt_end) begin
               w_tx_nxt     = S_DATA;
               w_tx_idx_nxt = '0;
            end
         end
         S_DATA: begin
            if (w_tx_cnt_end) begin
               if (r_tx_idx == c_IDX_LAST) begin
                  w_tx_idx_nxt  = '0;
                  w_tx_stop_nxt = 1'b0;
                  w_tx_nxt      = c_PAR_EN ? S_PARITY : S_STOP;
               end else begin
                  w_tx_idx_nxt = r_tx_idx + 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (w_tx_cnt_end) begin
               w_tx_nxt      = S_STOP;
               w_tx_stop_nxt = 1'b0;
            end
         end
         S_STOP: begin
            if (w_tx_cnt_end) begin
               if (r_tx_stop == c_STOP_LAST) w_tx_nxt = S_IDLE;
               else                          w_tx_stop_nxt = 1'b1;
            end
         end
         default: w_tx_nxt = S_IDLE;
      endcase
      // Line level is decoded from the next state so it is registered in step
      case (w_tx_nxt)
         S_START:  w_tx_line = 1'b0;
         S_DATA:   w_tx_line = r_tx_data[w_tx_idx_nxt];
         S_PARITY: w_tx_line = (^r_tx_data) ^ c_ODD;
         default:  w_tx_line = 1'b1;
      endcase
   end

   assign tx_channel_out = r_tx_line;
   assign tx_busy        = (r_tx_state != S_IDLE);

   // ------------------------------------------------------------------ RX
   state_t              r_rx_state, w_rx_nxt;
   logic                r_rx_meta, r_rx_sync, r_rx_prev;
   logic [c_CW-1:0]     r_rx_cnt;
   logic [c_IW-1:0]     r_rx_idx;
   logic                r_rx_stop, r_rx_s0, r_rx_s1, r_rx_par, r_rx_facc;
   logic [BIT_LEN-1:0]  r_rx_shift, r_rx_data;
   logic                r_rx_valid, r_rx_perr, r_rx_ferr;
   logic                w_rx_cnt_end, w_rx_vote, w_rx_vote_now, w_rx_perr;

   assign w_rx_cnt_end  = (r_rx_cnt == c_CNT_LAST);
   assign w_rx_vote     = (r_rx_s0 & r_rx_s1) | (r_rx_s0 & r_rx_sync) | (r_rx_s1 & r_rx_sync);
   assign w_rx_vote_now = (r_rx_cnt == c_S2) && (r_rx_state != S_IDLE);
   assign w_rx_perr     = c_PAR_EN & ((^r_rx_shift) ^ r_rx_par ^ c_ODD);

   always_comb begin
      w_rx_nxt = r_rx_state;
      case (r_rx_state)
         S_IDLE:   if (r_rx_prev && !r_rx_sync) w_rx_nxt = S_START;
         S_START: begin
            if (w_rx_vote_now && w_rx_vote) w_rx_nxt = S_IDLE;
            else if (w_rx_cnt_end)          w_rx_nxt = S_DATA;
         end
         S_DATA: begin
            if (w_rx_cnt_end && (r_rx_idx == c_IDX_LAST))
               w_rx_nxt = c_PAR_EN ? S_PARITY : S_STOP;
         end
         S_PARITY: if (w_rx_cnt_end) w_rx_nxt = S_STOP;
         S_STOP:   if (w_rx_vote_now && (r_rx_stop == c_STOP_LAST)) w_rx_nxt = S_IDLE;
         default:  w_rx_nxt = S_IDLE;
      endcase
   end

   // Synchronizer resets low so a line already low at reset release is not
   // mistaken for a start edge; only a genuine high-to-low transition counts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_meta  <= 1'b0;
         r_rx_sync  <= 1'b0;
         r_rx_prev  <= 1'b0;
         r_rx_state <= S_IDLE;
         r_rx_cnt   <= '0;
         r_rx_idx   <= '0;
         r_rx_stop  <= 1'b0;
         r_rx_s0    <= 1'b1;
         r_rx_s1    <= 1'b1;
         r_rx_par   <= 1'b0;
         r_rx_facc  <= 1'b0;
         r_rx_shift <= '0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
         r_rx_perr  <= 1'b0;
         r_rx_ferr  <= 1'b0;
      end else begin
         r_rx_meta  <= rx_channel_in;
         r_rx_sync  <= r_rx_meta;
         r_rx_prev  <= r_rx_sync;
         r_rx_state <= w_rx_nxt;
         if (r_rx_state == S_IDLE || w_rx_cnt_end) r_rx_cnt <= '0;
         else                                      r_rx_cnt <= r_rx_cnt + 1'b1;
         if (r_rx_cnt == c_S0) r_rx_s0 <= r_rx_sync;
         if (r_rx_cnt == c_S1) r_rx_s1 <= r_rx_sync;
         if (r_rx_state != S_STOP) r_rx_stop <= 1'b0;
         else if (w_rx_cnt_end)    r_rx_stop <= 1'b1;
         if (r_rx_state != S_DATA) r_rx_idx <= '0;
         else if (w_rx_cnt_end)    r_rx_idx <= (r_rx_idx == c_IDX_LAST) ? '0 : r_rx_idx + 1'b1;
         if (w_rx_vote_now) begin
            case (r_rx_state)
               S_START: begin
                  if (!w_rx_vote) begin
                     r_rx_valid <= 1'b0;
                     r_rx_perr  <= 1'b0;
                     r_rx_ferr  <= 1'b0;
                     r_rx_facc  <= 1'b0;
                  end
               end
               S_DATA:   r_rx_shift[r_rx_idx] <= w_rx_vote;
               S_PARITY: r_rx_par <= w_rx_vote;
               S_STOP: begin
                  if (!w_rx_vote) r_rx_facc <= 1'b1;
                  if (r_rx_stop == c_STOP_LAST) begin
                     r_rx_data  <= r_rx_shift;
                     r_rx_perr  <= w_rx_perr;
                     r_rx_ferr  <= r_rx_facc | ~w_rx_vote;
                     r_rx_valid <= ~(w_rx_perr | r_rx_facc | ~w_rx_vote);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign rx_data_out   = r_rx_data;
   assign rx_out_vaild  = r_rx_valid;
   assign rx_parity_err = r_rx_perr;
   assign rx_frame_err  = r_rx_ferr;
   assign rx_busy       = (r_rx_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_pe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_pe
//  Description : Directed bench: instance A transmits, instance B receives.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_pe;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       a_tx_start = 1'b0;
   logic [6:0] a_tx_data  = '0;
   logic       a_tx_out, a_tx_busy, a_rx_valid, a_rx_busy, a_perr, a_ferr;
   logic [6:0] a_rx_data;
   logic       b_tx_out, b_tx_busy, b_rx_valid, b_rx_busy, b_perr, b_ferr;
   logic [6:0] b_rx_data;
   logic       b_rx_in;
   logic       r_ovr  = 1'b0;
   logic       r_line = 1'b1;
   int         checks = 0;
   int         errors = 0;
   int         n;

   assign b_rx_in = r_ovr ? r_line : a_tx_out;

   uart_pe u_a (
      .clk(clk), .rst(rst), .tx_start(a_tx_start), .tx_data_in(a_tx_data),
      .tx_channel_out(a_tx_out), .tx_busy(a_tx_busy), .rx_channel_in(b_tx_out),
      .rx_data_out(a_rx_data), .rx_out_vaild(a_rx_valid), .rx_busy(a_rx_busy),
      .rx_parity_err(a_perr), .rx_frame_err(a_ferr)
   );

   uart_pe u_b (
      .clk(clk), .rst(rst), .tx_start(1'b0), .tx_data_in(7'd0),
      .tx_channel_out(b_tx_out), .tx_busy(b_tx_busy), .rx_channel_in(b_rx_in),
      .rx_data_out(b_rx_data), .rx_out_vaild(b_rx_valid), .rx_busy(b_rx_busy),
      .rx_parity_err(b_perr), .rx_frame_err(b_ferr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive cycles [from,to) of a 10-bit frame (8 clocks per bit, bit 0 = start)
   task automatic drive(input logic [9:0] f, input int from, input int to);
      for (int c = from; c < to; c++) begin
         r_line = f[c/8];
         tick();
      end
   endtask

   task automatic wait_rx_idle(input string tag);
      int k;
      k = 0;
      while (b_rx_busy && k < 200) begin
         tick();
         k++;
      end
      check(tag, 16'(b_rx_busy), 16'h0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      repeat (3) tick();
      check("rst_tx_out",  16'(a_tx_out),   16'h1);
      check("rst_tx_busy", 16'(a_tx_busy),  16'h0);
      check("rst_rx_busy", 16'(b_rx_busy),  16'h0);
      check("rst_rx_data", 16'(b_rx_data),  16'h0);
      check("rst_valid",   16'(b_rx_valid), 16'h0);
      check("rst_perr",    16'(b_perr),     16'h0);
      check("rst_ferr",    16'(b_ferr),     16'h0);
      rst = 1'b0;
      repeat (3) tick();

      // Loopback 1010011
      a_tx_data  = 7'b1010011;
      a_tx_start = 1'b1;
      tick();
      a_tx_start = 1'b0;
      check("tx_start_bit", 16'(a_tx_out), 16'h0);
      n = 0;
      while (a_tx_busy && n < 200) begin
         n++;
         tick();
      end
      check("tx_busy_len", 16'(n), 16'd80);
      wait_rx_idle("loop_rx_done");
      check("loop_data",  16'(b_rx_data),  16'h53);
      check("loop_valid", 16'(b_rx_valid), 16'h1);
      check("loop_perr",  16'(b_perr),     16'h0);
      check("loop_ferr",  16'(b_ferr),     16'h0);

      // Parity error: 0000001 with its even parity bit (1) inverted to 0
      r_line = 1'b1;
      r_ovr  = 1'b1;
      repeat (2) tick();
      drive(10'b1_0_0000001_0, 0, 80);
      r_line = 1'b1;
      wait_rx_idle("par_rx_done");
      check("par_perr",  16'(b_perr),     16'h1);
      check("par_valid", 16'(b_rx_valid), 16'h0);
      check("par_data",  16'(b_rx_data),  16'h01);
      check("par_ferr",  16'(b_ferr),     16'h0);

      // Frame error: 1111111, parity 1, stop bit forced low
      drive(10'b0_1_1111111_0, 0, 80);
      r_line = 1'b1;
      wait_rx_idle("frm_rx_done");
      check("frm_ferr",  16'(b_ferr),     16'h1);
      check("frm_valid", 16'(b_rx_valid), 16'h0);
      check("frm_perr",  16'(b_perr),     16'h0);
      check("frm_data",  16'(b_rx_data),  16'h7F);

      // One-cycle glitch on idle line: false start, outputs untouched
      repeat (4) tick();
      r_line = 1'b0;
      tick();
      r_line = 1'b1;
      repeat (20) tick();
      check("glitch_busy",  16'(b_rx_busy),  16'h0);
      check("glitch_data",  16'(b_rx_data),  16'h7F);
      check("glitch_ferr",  16'(b_ferr),     16'h1);
      check("glitch_valid", 16'(b_rx_valid), 16'h0);

      // 0101010 (parity 1) with one inverted clock mid data bit 3
      drive(10'b1_1_0101010_0, 0, 36);
      r_line = 1'b0;
      tick();
      drive(10'b1_1_0101010_0, 37, 80);
      r_line = 1'b1;
      wait_rx_idle("noise_rx_done");
      check("noise_data",  16'(b_rx_data),  16'h2A);
      check("noise_valid", 16'(b_rx_valid), 16'h1);

      // tx_start pulsed mid-frame must be ignored
      r_ovr = 1'b0;
      tick();
      a_tx_data  = 7'b0110110;
      a_tx_start = 1'b1;
      tick();
      a_tx_start = 1'b0;
      n = 0;
      while (a_tx_busy && n < 200) begin
         n++;
         a_tx_start = (n == 40);
         a_tx_data  = (n == 40) ? 7'b1111000 : 7'b0110110;
         tick();
      end
      a_tx_start = 1'b0;
      check("ign_busy_len", 16'(n), 16'd80);
      wait_rx_idle("ign_rx_done");
      check("ign_data",  16'(b_rx_data),  16'h36);
      check("ign_valid", 16'(b_rx_valid), 16'h1);
      repeat (3) tick();
      check("ign_no_queue", 16'(a_tx_busy), 16'h0);

      // Reset at cycle 35 of a frame (data bit 3 of 1010011 is 0 on the line)
      a_tx_data  = 7'b1010011;
      a_tx_start = 1'b1;
      tick();
      a_tx_start = 1'b0;
      repeat (35) tick();
      check("pre_rst_rx_busy", 16'(b_rx_busy), 16'h1);
      check("pre_rst_tx_out",  16'(a_tx_out),  16'h0);
      rst = 1'b1;
      #1;
      check("mid_rst_tx_out",  16'(a_tx_out),   16'h1);
      check("mid_rst_tx_busy", 16'(a_tx_busy),  16'h0);
      check("mid_rst_rx_busy", 16'(b_rx_busy),  16'h0);
      check("mid_rst_data",    16'(b_rx_data),  16'h0);
      check("mid_rst_valid",   16'(b_rx_valid), 16'h0);
      check("mid_rst_perr",    16'(b_perr),     16'h0);
      check("mid_rst_ferr",    16'(b_ferr),     16'h0);
      repeat (3) tick();
      rst = 1'b0;
      repeat (5) tick();

      // Back-to-back frames, zero idle: 1100101 (par 0) then 0011110 (par 0)
      r_line = 1'b1;
      r_ovr  = 1'b1;
      tick();
      drive(10'b1_0_1100101_0, 0, 80);
      drive(10'b1_0_0011110_0, 0, 1);
      check("b2b1_data",  16'(b_rx_data),  16'h65);
      check("b2b1_valid", 16'(b_rx_valid), 16'h1);
      drive(10'b1_0_0011110_0, 1, 80);
      r_line = 1'b1;
      wait_rx_idle("b2b2_rx_done");
      check("b2b2_data",  16'(b_rx_data),  16'h1E);
      check("b2b2_valid", 16'(b_rx_valid), 16'h1);
      check("b2b2_perr",  16'(b_perr),     16'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_pe.md
UART_PE -- requirements
Module: uart_pe

Interface
REQ-001 Parameter BIT_LEN, default 7: data bits per frame, legal range 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 8: clocks per bit period, legal minimum 4.
REQ-003 Parameter PARITY_MODE, default 1: 0 none, 1 even, 2 odd.
REQ-004 Parameter STOP_BITS, default 1: stop bits per frame, 1 or 2.
REQ-005 Clocking and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  clock, rising-edge.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 tx_start  in  1  request to send tx_data_in.
REQ-009 tx_data_in  in  BIT_LEN  transmit word.
REQ-010 tx_channel_out  out  1  serial line, idle high.
REQ-011 tx_busy  out  1  transmitter not idle.
REQ-012 rx_channel_in  in  1  serial line, asynchronous to clk.
REQ-013 rx_data_out  out  BIT_LEN  last received word.
REQ-014 rx_out_vaild  out  1  last frame received without error.
REQ-015 rx_busy  out  1  receiver not idle.
REQ-016 rx_parity_err  out  1  last frame failed parity.
REQ-017 rx_frame_err  out  1  last frame had a low stop bit.

Function
REQ-018 Frame format SHALL be: start bit (0), then BIT_LEN data bits LSB first, then a parity bit if PARITY_MODE!=0, then STOP_BITS stop bits (1).
- Frame length L = 1 + BIT_LEN + (PARITY_MODE!=0) + STOP_BITS bits.
- Every bit SHALL last exactly CLKS_PER_BIT clocks.
REQ-019 Even parity: XOR of the data bits and the parity bit SHALL be 0; odd parity: that XOR SHALL be 1.
REQ-020 The TX FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY_MODE=0.
- TX state advances when its bit counter reaches CLKS_PER_BIT-1.
- The TX data-bit index wraps back to 0 after BIT_LEN-1.
REQ-021 tx_start SHALL be accepted only in IDLE.
- On acceptance, tx_data_in is latched on that edge.
- tx_channel_out is registered and drives 0 from the next cycle.
- tx_busy SHALL be high for exactly L*CLKS_PER_BIT cycles.
REQ-022 tx_start while tx_busy=1 SHALL be ignored, with no queuing.
- After the last stop bit, TX SHALL spend at least one cycle in IDLE before accepting a new start.
REQ-023 rx_channel_in SHALL pass through a 2-flop synchronizer before use.
REQ-024 The RX FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
- IDLE->START on a synchronized high-to-low transition.
REQ-025 Each bit SHALL be decided by majority vote of 3 samples taken at counts CLKS_PER_BIT/2-1, CLKS_PER_BIT/2 and CLKS_PER_BIT/2+1 within the bit.
REQ-026 If the voted start bit is 1, RX SHALL return to IDLE with all outputs unchanged (false start).
REQ-027 On detection of a valid start bit, rx_out_vaild, rx_parity_err and rx_frame_err SHALL clear.
REQ-028 Completion is the cycle after the vote of the last stop bit. At completion:
- rx_data_out SHALL update with the received word.
- rx_parity_err SHALL be set per REQ-019 (always 0 when PARITY_MODE=0).
- rx_frame_err SHALL be set if any stop bit voted 0.
- rx_out_vaild SHALL equal NOT(rx_parity_err OR rx_frame_err).
- RX returns to IDLE.
REQ-029 rx_data_out and all three status flags SHALL hold their values until the next valid start bit or reset.
REQ-030 rx_busy SHALL be high from the cycle after start detection until RX returns to IDLE.
REQ-031 TX and RX SHALL operate independently and concurrently.
- The receiver SHALL accept back-to-back frames with zero idle bits between them.

Reset
REQ-032 While rst=1, both FSMs SHALL be in IDLE.
REQ-033 Reset values while rst=1: tx_channel_out=1, tx_busy=0, rx_busy=0, rx_data_out=0, rx_out_vaild=0, rx_parity_err=0, rx_frame_err=0.
REQ-034 Reset asserted mid-frame SHALL abort both directions immediately; no partial word or flag SHALL become visible.
REQ-035 After rst deasserts, a partial frame still on rx_channel_in SHALL only be accepted from its next falling edge.

Verification
All scenarios use BIT_LEN=7, CLKS_PER_BIT=8, PARITY_MODE=1, STOP_BITS=1 (L=10), with two instances cross-connected.
REQ-036 Loopback: send 7'b1010011 -> rx_data_out=1010011, rx_out_vaild=1, both error flags 0; tx_busy high for exactly 80 cycles.
REQ-037 Parity error: invert the parity bit of 7'b0000001 on the line -> rx_parity_err=1, rx_out_vaild=0, rx_data_out=0000001.
REQ-038 Frame error: force the stop bit to 0 for 7'b1111111 -> rx_frame_err=1, rx_out_vaild=0.
REQ-039 Noise immunity:
- A 1-cycle low glitch on the idle line -> no frame, outputs unchanged.
- A 1-cycle inverted pulse at the centre of data bit 3 of 7'b0101010 -> data correct, rx_out_vaild=1.
REQ-040 Reset and back-to-back:
- Assert rst at cycle 35 of a frame -> tx_channel_out=1, rx_busy=0, all flags 0 within the same cycle.
- Two frames with zero idle gap on the line -> both received correctly.
- tx_start pulsed mid-frame -> ignored.
